// File: rtl/ac1c2_to_rgb.sv
// ac1c2_to_rgb -- converts one A/C1/C2 sample (signed Q16.16) into 8-bit R/G/B.
//
// Each output channel is clamp(round((k0*A + k1*C1 + k2*C2) >>> 29)). The 3x3
// Q3.13 coefficient matrix is runtime-writable and resets to identity.
//
// The datapath is a three-stage valid/ready pipeline:
//   S1 products -> S2 row sums -> S3 round/clamp.
// S3 is the output register itself.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_valid / o_ready         input handshake
//   i_A, i_C1, i_C2           signed Q16.16 inputs
//   o_valid / i_ready         output handshake
//   o_R, o_G, o_B             unsigned 8-bit pixel components
//   o_clip                    clamp flags {B,G,R}
//   i_coef_we/_addr/_data     coefficient write port (index 0..8, row-major)

// Coefficient register file. Indices 0..8 are R row, G row, B row; the columns
// within each row are A, C1, C2. Addresses 9..15 decode to nothing.
module ac1c2_coef_regs (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [3:0]       i_addr,
  input  logic [15:0]      i_data,
  output logic [8:0][15:0] o_coef
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 9; i++)
        o_coef[i] <= (i == 0 || i == 4 || i == 8) ? 16'h2000 : 16'h0000;
    end else begin
      for (int i = 0; i < 9; i++)
        if (i_we && i_addr == 4'(i))
          o_coef[i] <= i_data;
    end
  end

endmodule

module ac1c2_to_rgb #(
  parameter int ROUND_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_A,
  input  logic [31:0] i_C1,
  input  logic [31:0] i_C2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_R,
  output logic [7:0]  o_G,
  output logic [7:0]  o_B,
  output logic [2:0]  o_clip,
  input  logic        i_coef_we,
  input  logic [3:0]  i_coef_addr,
  input  logic [15:0] i_coef_data
);

  localparam logic signed [49:0] RND_ADD = (ROUND_EN != 0) ? 50'sd268435456 : 50'sd0;

  logic [8:0][15:0] coef;

  ac1c2_coef_regs u_coef_regs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (i_coef_we),
    .i_addr  (i_coef_addr),
    .i_data  (i_coef_data),
    .o_coef  (coef)
  );

  // Stage load enables: a stage loads when empty or when its content moves on.
  logic s1_v, s2_v;
  logic ld1, ld2, ld3, accept;

  assign ld3     = !o_valid || i_ready;
  assign ld2     = !s2_v || ld3;
  assign ld1     = !s1_v || ld2;
  assign o_ready = ld1;
  assign accept  = i_valid && o_ready;

  // S1: products. The register file is read combinationally here, so a write
  // landing on the same edge as an accept is seen only by later samples.
  logic signed [47:0] x_ext [3];
  logic signed [47:0] prod  [9];
  logic signed [47:0] s1_p  [9];

  always_comb begin
    x_ext[0] = 48'(signed'(i_A));
    x_ext[1] = 48'(signed'(i_C1));
    x_ext[2] = 48'(signed'(i_C2));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        prod[r*3+c] = 48'(signed'(coef[r*3+c])) * x_ext[c];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v <= 1'b0;
      for (int i = 0; i < 9; i++) s1_p[i] <= '0;
    end else begin
      if (ld1) s1_v <= i_valid;
      if (accept)
        for (int i = 0; i < 9; i++) s1_p[i] <= prod[i];
    end
  end

  // S2: row sums, 50 bits so three full-scale products cannot overflow.
  logic signed [49:0] sum_c [3];
  logic signed [49:0] s2_sum [3];

  always_comb begin
    for (int r = 0; r < 3; r++)
      sum_c[r] = 50'(s1_p[r*3]) + 50'(s1_p[r*3+1]) + 50'(s1_p[r*3+2]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_v <= 1'b0;
      for (int r = 0; r < 3; r++) s2_sum[r] <= '0;
    end else begin
      if (ld2) s2_v <= s1_v;
      if (ld2 && s1_v)
        for (int r = 0; r < 3; r++) s2_sum[r] <= sum_c[r];
    end
  end

  // S3: drop the 29 fractional bits, then saturate to 0..255.
  logic signed [49:0] shifted [3];
  logic [7:0]         pix     [3];
  logic [2:0]         clp;

  always_comb begin
    clp = '0;
    for (int r = 0; r < 3; r++) begin
      shifted[r] = (s2_sum[r] + RND_ADD) >>> 29;
      pix[r]     = shifted[r][7:0];
      if (shifted[r] < 0) begin
        pix[r] = 8'd0;
        clp[r] = 1'b1;
      end else if (shifted[r] > 50'sd255) begin
        pix[r] = 8'd255;
        clp[r] = 1'b1;
      end
    end
  end

  // Output data only updates when a real sample arrives, so values hold
  // through stalls and bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_R     <= '0;
      o_G     <= '0;
      o_B     <= '0;
      o_clip  <= '0;
    end else begin
      if (ld3) o_valid <= s2_v;
      if (ld3 && s2_v) begin
        o_R    <= pix[0];
        o_G    <= pix[1];
        o_B    <= pix[2];
        o_clip <= clp;
      end
    end
  end

endmodule

// File: doc/ac1c2_to_rgb.md
AC1C2_TO_RGB -- requirements
Module: ac1c2_to_rgb

Interface
REQ-001 Parameter: ROUND_EN, default 1, meaning 1 = round-half-up and 0 = truncate at the final shift.
REQ-002 Port: i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_valid  input  1  input sample valid.
REQ-005 Port: o_ready  output  1  block can accept a sample this cycle.
REQ-006 Ports: i_A, i_C1, i_C2  input  32 each  signed Q16.16 (16 fractional bits), same format the RGB2AC1C2 block produces on o_A/o_C1/o_C2.
REQ-007 Port: o_valid  output  1  output sample valid.
REQ-008 Port: i_ready  input  1  downstream accepts the output this cycle.
REQ-009 Ports: o_R, o_G, o_B  output  8 each  unsigned pixel components.
REQ-010 Port: o_clip  output  3  per-sample clamp flags {B,G,R}; a bit is 1 when that channel was clamped.
REQ-011 Port: i_coef_we  input  1  coefficient write strobe.
REQ-012 Port: i_coef_addr  input  4  coefficient index 0..8, row-major: row R = 0..2, row G = 3..5, row B = 6..8; each row's columns are A, C1, C2.
REQ-013 Port: i_coef_data  input  16  signed Q3.13 coefficient.

Function
REQ-014 Each output channel SHALL be computed as clamp(round((k0*A + k1*C1 + k2*C2) >> 29)), using that channel's coefficient row; the shift removes 16+13 fractional bits.
REQ-015 Each product SHALL be full-precision signed 48-bit; the three-term sum SHALL be 50-bit signed, with no intermediate truncation.
REQ-016 Rounding SHALL depend on ROUND_EN:
- ROUND_EN=1: add 2^28 before the arithmetic shift.
- ROUND_EN=0: shift only.
REQ-017 Clamp: a shifted result below 0 SHALL give 0 and a result above 255 SHALL give 255; in both cases the channel's o_clip bit SHALL be set.
REQ-018 Pipeline SHALL have 3 stages:
- S1: capture products.
- S2: sum.
- S3: round/clamp into the output registers.
REQ-019 Latency: a sample accepted in cycle N SHALL appear on o_valid in cycle N+3 when there is no backpressure.
REQ-020 An input is accepted when i_valid && o_ready; an output is consumed when o_valid && i_ready.
REQ-021 Each stage SHALL carry a valid bit, and a stage SHALL load when it is empty or its contents are advancing (bubbles collapse).
REQ-022 o_ready SHALL equal !S1_valid || S1 advancing; this combinational path from i_ready is permitted.
REQ-023 While o_valid && !i_ready, o_R/o_G/o_B/o_clip SHALL hold stable; the block SHALL never drop, duplicate or reorder samples.
REQ-024 Throughput SHALL be 1 sample/cycle while i_ready=1.
REQ-025 Coefficients SHALL be sampled at acceptance; a sample already in flight SHALL keep the coefficients it was accepted with.
REQ-026 A write in cycle N SHALL take effect for samples accepted in cycle N+1 onward.
REQ-027 A sample accepted in the same cycle as a write SHALL use the old value.
REQ-028 Writes to i_coef_addr 9..15 SHALL be ignored.
REQ-029 Writes SHALL be permitted at any time, including during a stall.
REQ-030 Back-to-back writes to the same address: the last write SHALL win.

Reset
REQ-031 When i_rst_n=0, the following SHALL hold immediately, independent of i_clk:
- all stage valid bits clear;
- o_valid=0, o_R/o_G/o_B=0, o_clip=0;
- coefficient matrix = identity (diagonal 0x2000 = 1.0, off-diagonal 0x0000).
REQ-032 Reset mid-operation SHALL discard all in-flight samples, and no partial result SHALL appear after release.
REQ-033 o_ready SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-034 Identity pass-through: after reset, A=0x00640000, C1=0x00C80000, C2=0x00320000 with i_ready=1 -> exactly 3 cycles later R=100, G=200, B=50, o_clip=000.
REQ-035 Clamp and round: with identity coefficients:
- A=0xFFFF0000 -> R=0, o_clip[0]=1.
- A=0x01000000 -> R=255, o_clip[0]=1.
- ROUND_EN=1: A=0x00008000 -> R=1; A=0x00007FFF -> R=0.
- ROUND_EN=0: A=0x0000FFFF -> R=0.
REQ-036 Coefficient write: write addr 1 = 0x1000 (0.5), then next cycle A=0x000A0000, C1=0x00640000, C2=0 -> R=60, G=100.
- Repeat with the same-cycle write/accept variant, where the accepted sample must give R=10.
REQ-037 Backpressure: stream samples 1..5 (A=1.0..5.0), hold i_ready=0 for 5 cycles once o_valid rises -> o_ready falls, o_R=1 held stable, then R=1,2,3,4,5 in order with none lost or repeated.
REQ-038 Reset mid-stream: drop i_rst_n for 1 cycle with 3 samples in flight and a non-identity coefficient loaded -> o_valid=0 asynchronously, no stale output after release, and the next sample uses identity.
